aes_shift_pipe: RTL
===================

AES_SHIFT_PIPE -- requirements
Module: aes_shift_pipe

Interface
REQ-001 Parameter NB, default 4, meaning number of state columns (legal values 4, 6, 8; Rijndael block of 32*NB bits).
REQ-002 Parameter TAG_W, default 4, meaning width of sideband tag carried alongside each state (round number or similar).
REQ-003 Port clk  input  1  meaning sole clock, all logic on rising edge.
REQ-004 Port rst  input  1  meaning synchronous, active-high reset.
REQ-005 Port in_valid  input  1  meaning input transaction present.
REQ-006 Port in_ready  output  1  meaning block can accept input this cycle.
REQ-007 Port in_inv  input  1  meaning 0 = ShiftRows, 1 = InvShiftRows, sampled per transaction.
REQ-008 Port in_state  input  32*NB  meaning state bytes, byte b at bits [8*(4*NB-1-b)+7 : 8*(4*NB-1-b)], so byte 0 is the MSB byte.
REQ-009 Port in_tag  input  TAG_W  meaning sideband tag, passed through unmodified.
REQ-010 Port out_valid  output  1  meaning output transaction present.
REQ-011 Port out_ready  input  1  meaning downstream accepts output this cycle.
REQ-012 Port out_state  output  32*NB  meaning shifted state, same byte packing as in_state.
REQ-013 Port out_tag  output  TAG_W  meaning tag of the transaction on out_state.
REQ-014 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-015 Byte b SHALL map to row r = b mod 4, column c = b / 4 (FIPS-197 column-major order).
REQ-016 Row shift offsets SHALL be {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-017 Forward mode SHALL produce out(r,c) = in(r,(c+off[r]) mod NB).
REQ-018 Inverse mode SHALL produce out(r,c) = in(r,(c-off[r]) mod NB), with the mod result always non-negative.
REQ-019 Elaboration SHALL fail for any NB outside {4,6,8}.
REQ-020 Transform SHALL be applied on input and the result stored in a 2-entry FIFO (state + tag).
REQ-021 Handshake: a transfer occurs on a cycle with valid && ready on that side.
REQ-022 A presented valid transaction SHALL be held stable by the source until accepted; the block SHALL hold out_* stable while out_valid && !out_ready.
REQ-023 in_ready SHALL be driven only from the registered occupancy: in_ready = (count < 2), with no combinational path from out_ready.
REQ-024 Latency: a state accepted in cycle N SHALL appear on out_state no earlier than cycle N+1, and in cycle N+1 when the FIFO was empty.
REQ-025 Throughput SHALL be one transaction per cycle with out_ready held high.
REQ-026 Ordering SHALL be strictly FIFO; in_inv and in_tag SHALL be bound to their own transaction.
REQ-027 Simultaneous push and pop with count=1: count stays 1, the popped entry leaves, and the new entry becomes head next cycle.
REQ-028 count=2: in_ready=0; a pop in that cycle SHALL raise in_ready in the following cycle.
REQ-029 count=0: out_valid=0, and out_state/out_tag SHALL hold the last popped value (0 after reset).
REQ-030 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-031 While rst=1: count=0, pointers=0, out_valid=0, out_state=0, out_tag=0, and in_ready=0.
REQ-032 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-033 Reset mid-operation SHALL discard all stored transactions; no stale output SHALL appear after reset.

Verification
REQ-034 NB=4, fwd, in_state=d42711aee0bf98f1b8b45de51e415230 (hex) -> out_state=d4bf5d30e0b452aeb84111f11e2798e5 one cycle later.
REQ-035 NB=4, inv, in_state=d4bf5d30e0b452aeb84111f11e2798e5 -> out_state=d42711aee0bf98f1b8b45de51e415230.
REQ-036 NB=8, fwd, in bytes 00..1f ramp -> out bytes 0..3 = 00 05 0e 13; inv of that result returns the ramp.
REQ-037 out_ready=0, three back-to-back inputs with tags 1,2,3 -> two accepted, in_ready=0 on the third; release out_ready -> tags 1,2,3 out in order, no loss or duplication.
REQ-038 Continuous in_valid/out_ready with random data, random in_inv and NB in {4,6,8} -> 1 transaction/cycle; all outputs match the reference model.
REQ-039 rst asserted with count=2 -> next cycle out_valid=0 and out_state=0; after release, first new input emerges with no stale entries.

Source files
------------

// File: rtl/aes_shift_pipe.sv
// Rijndael ShiftRows / InvShiftRows for NB = 4, 6 or 8 columns. The state is shifted as it
// enters and is stored, with its tag, in a 2-entry FIFO that drives the output side.
module aes_shift_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [32*NB-1:0]    in_state,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_state,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_pipe: NB must be 4, 6 or 8");
  end

  // Handshake: a transfer happens on any cycle where valid && ready on that side; a
  // presented transaction stays stable until taken, and out_* hold while stalled.

  // Row offsets: rows 2 and 3 shift one further for 256-bit blocks.
  function automatic int row_off(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  logic [W-1:0]     shifted;
  logic [W-1:0]     mem_state_q [2];
  logic [TAG_W-1:0] mem_tag_q   [2];
  logic [W-1:0]     last_state_q;
  logic [TAG_W-1:0] last_tag_q;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  // Byte b sits at row b%4, column b/4; byte 0 is the most significant byte.
  always_comb begin
    int src_c;
    shifted = '0;
    src_c   = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (in_inv) src_c = (c - row_off(r) + NB) % NB;
        else        src_c = (c + row_off(r)) % NB;
        shifted[8*(4*NB-1-(4*c+r)) +: 8] = in_state[8*(4*NB-1-(4*src_c+r)) +: 8];
      end
    end
  end

  assign in_ready  = !rst && (count_q < 2'd2);
  assign out_valid = !rst && (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // An empty FIFO keeps presenting the last entry that left it.
  assign out_state = (count_q != 2'd0) ? mem_state_q[rd_ptr_q] : last_state_q;
  assign out_tag   = (count_q != 2'd0) ? mem_tag_q[rd_ptr_q]   : last_tag_q;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      last_state_q <= '0;
      last_tag_q   <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (pop) begin
        last_state_q <= mem_state_q[rd_ptr_q];
        last_tag_q   <= mem_tag_q[rd_ptr_q];
      end
    end
  end

  // Entry storage needs no reset: it is only visible while count_q covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_state_q[wr_ptr_q] <= shifted;
      mem_tag_q[wr_ptr_q]   <= in_tag;
    end
  end

endmodule
